// File: rtl/cmd_dispatch_module_if.sv
// rtl/cmd_dispatch_module_if.sv - FIFO and function-channel signal bundle of the command dispatcher
interface cmd_dispatch_module_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 2
);
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_empty;
  logic              fifo_rd_req;
  logic [NUM_CH-1:0] func_done;
  logic [NUM_CH-1:0] func_start;
  logic              busy;
  logic              err_unknown;
  logic              err_timeout;

  modport master (
    input  fifo_rd_data, fifo_empty, func_done,
    output fifo_rd_req, func_start, busy, err_unknown, err_timeout
  );

  modport slave (
    output fifo_rd_data, fifo_empty, func_done,
    input  fifo_rd_req, func_start, busy, err_unknown, err_timeout
  );
endinterface

// File: rtl/cmd_dispatch_module.sv
// rtl/cmd_dispatch_module.sv - fetches one command code from a FIFO and runs the matching function channel
module cmd_dispatch_module #(
  parameter int                         DATA_W    = 8,
  parameter int                         NUM_CH    = 2,
  parameter logic [NUM_CH*DATA_W-1:0]   CMD_CODES = {8'h1B, 8'h44},
  parameter int                         RD_LAT    = 1,
  parameter int                         TIMEOUT   = 0
) (
  input  logic clk,
  input  logic rst,
  cmd_dispatch_module_if.master bus
);

  localparam int TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int LAT_W = $clog2(RD_LAT + 1);
  localparam int CNT_W = (TO_W > LAT_W) ? TO_W : LAT_W;

  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ   = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_DECODE = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] cmd_q;
  logic [NUM_CH-1:0] start_q;
  logic [NUM_CH-1:0] hit_vec;
  logic              unk_q;
  logic              to_q;
  logic              done_hit;
  logic              timeout_hit;

  // Scan from the top down so the lowest-index duplicate code ends up selected.
  always_comb begin
    hit_vec = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (cmd_q == CMD_CODES[k*DATA_W +: DATA_W]) begin
        hit_vec = NUM_CH'(1) << k;
      end
    end
  end

  assign done_hit    = |(bus.func_done & start_q);
  assign timeout_hit = (TIMEOUT > 0) && (cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      cmd_q   <= '0;
      start_q <= '0;
      unk_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      unk_q <= 1'b0;
      to_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!bus.fifo_empty) begin
            state <= S_READ;
          end
        end
        S_READ: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == LAT_LAST) begin
            cmd_q <= bus.fifo_rd_data;
            state <= S_DECODE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DECODE: begin
          cnt <= '0;
          if (|hit_vec) begin
            start_q <= hit_vec;
            state   <= S_RUN;
          end else begin
            unk_q <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          // Done of the selected channel takes priority over an expiring timeout.
          if (done_hit) begin
            start_q <= '0;
            state   <= S_IDLE;
          end else if (timeout_hit) begin
            start_q <= '0;
            to_q    <= 1'b1;
            state   <= S_IDLE;
          end else if (TIMEOUT > 0) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.fifo_rd_req = (state == S_READ);
  assign bus.busy        = (state != S_IDLE);
  assign bus.func_start  = start_q;
  assign bus.err_unknown = unk_q;
  assign bus.err_timeout = to_q;

endmodule

// File: tb/tb_cmd_dispatch_module.sv
// tb/tb_cmd_dispatch_module.sv - randomized self-checking bench for cmd_dispatch_module in two configurations
module tb_cmd_dispatch_module;

  localparam int NCYC       = 3000;
  localparam int RAND_START = 200;

  typedef struct {
    logic [7:0] code;
    int         n;
    int         rst_off;
  } cmd_t;

  logic clk = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_env
    localparam int NCH = (g == 0) ? 2 : 4;
    localparam int RL  = (g == 0) ? 1 : 2;
    localparam int TO  = (g == 0) ? 0 : 6;
    localparam logic [31:0]      CODES_ALL = (g == 0) ? 32'h0000_1B44 : 32'hA05C_A011;
    localparam logic [NCH*8-1:0] CODES     = CODES_ALL[NCH*8-1:0];

    logic rst;
    bit   done_f = 1'b0;
    cmd_t q[$];

    cmd_dispatch_module_if #(.DATA_W(8), .NUM_CH(NCH)) bus ();

    cmd_dispatch_module #(
      .DATA_W(8), .NUM_CH(NCH), .CMD_CODES(CODES), .RD_LAT(RL), .TIMEOUT(TO)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );

    initial begin
      int idle_from, rec_t, rec_s, rec_end, rec_ch, done_cyc, data_due, rst_cyc, n, idx;
      bit rec_valid, rec_to, rst_prev, empty_prev, exp_rd;
      logic [7:0]       data_val;
      logic [NCH-1:0]   sel, exp_start;
      logic [NCH*8-1:0] codes_v;
      cmd_t cm;

      codes_v   = CODES;
      rst       = 1'b1;
      bus.fifo_empty   = 1'b1;
      bus.fifo_rd_data = '0;
      bus.func_done    = '0;
      rst_prev  = 1'b1;
      empty_prev = 1'b1;
      rec_valid = 1'b0;
      rec_to    = 1'b0;
      rec_t = 0; rec_s = 0; rec_end = 0; rec_ch = -1;
      idle_from = 0; done_cyc = -1; data_due = -1; rst_cyc = -1;
      data_val  = '0;
      sel       = '0;

      if (g == 0) begin
        q.push_back('{code: 8'h44, n: 5,  rst_off: -1});
        q.push_back('{code: 8'h1B, n: 3,  rst_off: -1});
        q.push_back('{code: 8'h55, n: 1,  rst_off: -1});
        q.push_back('{code: 8'h44, n: 1,  rst_off: -1});
        q.push_back('{code: 8'h1B, n: 40, rst_off: 3});
      end else begin
        q.push_back('{code: 8'hA0, n: 2,   rst_off: -1});
        q.push_back('{code: 8'h11, n: 6,   rst_off: -1});
        q.push_back('{code: 8'h5C, n: 100, rst_off: -1});
        q.push_back('{code: 8'hA0, n: 4,   rst_off: -1});
        q.push_back('{code: 8'h33, n: 1,   rst_off: -1});
      end

      for (int c = 0; c < NCYC; c++) begin
        @(posedge clk);
        #1;
        if (rst_prev) begin
          rec_valid = 1'b0;
          idle_from = c;
          exp_rd    = 1'b0;
          done_cyc  = -1;
          data_due  = -1;
          sel       = '0;
        end else begin
          exp_rd = !empty_prev && (c - 1 >= idle_from);
        end

        // A fetch at cycle c: start or error shows RL+2 cycles later, run length from the command plan.
        if (exp_rd && q.size() > 0) begin
          cm        = q.pop_front();
          rec_valid = 1'b1;
          rec_t     = c;
          rec_s     = c + RL + 2;
          rec_ch    = -1;
          for (int k = 0; k < NCH; k++) begin
            if (rec_ch < 0 && cm.code == codes_v[k*8 +: 8]) rec_ch = k;
          end
          n = cm.n;
          if (rec_ch < 0) begin
            rec_to   = 1'b0;
            rec_end  = rec_s;
            sel      = '0;
            done_cyc = -1;
          end else begin
            sel      = NCH'(1) << rec_ch;
            rec_to   = (TO > 0) && (n > TO);
            rec_end  = rec_s + (rec_to ? TO : n);
            done_cyc = rec_to ? -1 : rec_s + n - 1;
          end
          idle_from = rec_end;
          data_due  = c + RL;
          data_val  = cm.code;
          rst_cyc   = (cm.rst_off >= 0) ? rec_s + cm.rst_off : -1;
        end

        exp_start = (rec_valid && rec_ch >= 0 && c >= rec_s && c < rec_end) ? sel : '0;
        chk($sformatf("e%0d c%0d fifo_rd_req", g, c), 32'(bus.fifo_rd_req), 32'(exp_rd));
        chk($sformatf("e%0d c%0d busy", g, c), 32'(bus.busy),
            32'(rec_valid && c >= rec_t && c < rec_end));
        chk($sformatf("e%0d c%0d func_start", g, c), 32'(bus.func_start), 32'(exp_start));
        chk($sformatf("e%0d c%0d err_unknown", g, c), 32'(bus.err_unknown),
            32'(rec_valid && rec_ch < 0 && c == rec_s));
        chk($sformatf("e%0d c%0d err_timeout", g, c), 32'(bus.err_timeout),
            32'(rec_valid && rec_to && c == rec_end));

        if (c >= RAND_START && q.size() < 3 && $urandom_range(3) == 0) begin
          idx = $urandom_range(NCH - 1);
          cm.code    = ($urandom_range(3) == 0) ? 8'($urandom) : codes_v[idx*8 +: 8];
          cm.n       = $urandom_range((TO > 0) ? TO + 3 : 8, 1);
          cm.rst_off = ($urandom_range(59) == 0) ? int'($urandom_range(4)) : -1;
          q.push_back(cm);
        end

        rst      = (c < 3) || (c == rst_cyc);
        rst_prev = rst;
        bus.fifo_empty = (q.size() == 0) || (c >= RAND_START && $urandom_range(4) == 0);
        empty_prev     = bus.fifo_empty;
        bus.fifo_rd_data = (c == data_due) ? data_val : ~data_val;
        bus.func_done    = (c < RAND_START) ? ~sel : (NCH'($urandom) & ~sel);
        if (c == done_cyc) bus.func_done = bus.func_done | sel;
      end
      done_f = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < NCYC + 100 && !(g_env[0].done_f && g_env[1].done_f); i++) begin
      @(posedge clk);
    end
    chk("env_done", {30'b0, g_env[1].done_f, g_env[0].done_f}, 32'd3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
